// File: rtl/inst_loader_if.sv
// Byte-stream handshake and instruction-memory write bus for inst_loader.
// master: upstream byte source / memory side; slave: the loader itself.
interface inst_loader_if #(
    parameter int A = 10,
    parameter int W = 9
) ();
    logic         byte_valid;
    logic [7:0]   byte_data;
    logic         byte_ready;
    logic         wr_en;
    logic [A-1:0] wr_addr;
    logic [W-1:0] wr_data;

    modport master (
        output byte_valid, byte_data,
        input  byte_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/inst_loader.sv
// Instruction memory loader: parses a 16-bit little-endian word count, then
// assembles W-bit words from byte pairs and strobes them into instruction
// memory at incrementing addresses. Holds the CPU in reset until done.
// Optional trailer checksum (XOR of all instruction bytes) is enabled by
// defining INST_LOADER_CHECKSUM_EN.
module inst_loader #(
    parameter int A = 10,
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    inst_loader_if.slave bus,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic         cpu_hold
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_INST_LO,
        S_INST_HI,
`ifdef INST_LOADER_CHECKSUM_EN
        S_CKSUM,
`endif
        S_DONE,
        S_ERR
    } state_t;

    // High-byte bits above the word width must be zero.
    localparam logic [7:0]  HI_MASK = 8'(8'hFF << (W - 8));
    localparam logic [16:0] LEN_MAX = 17'(1) << A;

    state_t       state_q;
    logic [15:0]  len_q;
    logic [7:0]   lo_q;
    logic [A-1:0] idx_q;
    logic         byte_ready_q;
    logic         wr_en_q;
    logic [W-1:0] wr_data_q;
    logic         busy_q, done_q, error_q, cpu_hold_q;
`ifdef INST_LOADER_CHECKSUM_EN
    logic [7:0]   cks_q;
`endif

    logic [7:0]   b;
    logic         take;
    logic [15:0]  len_d;
    logic [W-1:0] word_d;
    logic         last_word;
    logic         bad_len;

    assign b         = bus.byte_data;
    assign take      = bus.byte_valid & byte_ready_q;
    assign len_d     = {b, len_q[7:0]};
    assign word_d    = W'({b, lo_q});
    // idx_q still names the word being (or just) assembled here.
    assign last_word = (17'(idx_q) + 17'd1) == {1'b0, len_q};
    assign bad_len   = (len_d == 16'd0) || ({1'b0, len_d} > LEN_MAX);

    // Loader FSM with all outputs registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            lo_q         <= '0;
            idx_q        <= '0;
            byte_ready_q <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_data_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            cpu_hold_q   <= 1'b1;
`ifdef INST_LOADER_CHECKSUM_EN
            cks_q        <= '0;
`endif
        end else begin
            wr_en_q <= 1'b0;
            // Advance past a word once its strobe is out; the final word's
            // address is kept so wr_addr ends at len-1 and never wraps.
            if (wr_en_q && !last_word) idx_q <= idx_q + A'(1);
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state_q      <= S_LEN_LO;
                        idx_q        <= '0;
                        done_q       <= 1'b0;
                        error_q      <= 1'b0;
                        cpu_hold_q   <= 1'b1;
                        busy_q       <= 1'b1;
                        byte_ready_q <= 1'b1;
`ifdef INST_LOADER_CHECKSUM_EN
                        cks_q        <= '0;
`endif
                    end
                end
                S_LEN_LO: begin
                    if (take) begin
                        len_q[7:0] <= b;
                        state_q    <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (take) begin
                        len_q[15:8] <= b;
                        if (bad_len) begin
                            state_q      <= S_ERR;
                            error_q      <= 1'b1;
                            busy_q       <= 1'b0;
                            byte_ready_q <= 1'b0;
                        end else begin
                            state_q <= S_INST_LO;
                        end
                    end
                end
                S_INST_LO: begin
                    if (take) begin
                        lo_q    <= b;
                        state_q <= S_INST_HI;
`ifdef INST_LOADER_CHECKSUM_EN
                        cks_q   <= cks_q ^ b;
`endif
                    end
                end
                S_INST_HI: begin
                    if (take) begin
                        if ((b & HI_MASK) != 8'd0) begin
                            state_q      <= S_ERR;
                            error_q      <= 1'b1;
                            busy_q       <= 1'b0;
                            byte_ready_q <= 1'b0;
                        end else begin
                            wr_en_q   <= 1'b1;
                            wr_data_q <= word_d;
`ifdef INST_LOADER_CHECKSUM_EN
                            cks_q     <= cks_q ^ b;
                            state_q   <= last_word ? S_CKSUM : S_INST_LO;
`else
                            if (last_word) begin
                                state_q      <= S_DONE;
                                done_q       <= 1'b1;
                                cpu_hold_q   <= 1'b0;
                                busy_q       <= 1'b0;
                                byte_ready_q <= 1'b0;
                            end else begin
                                state_q <= S_INST_LO;
                            end
`endif
                        end
                    end
                end
`ifdef INST_LOADER_CHECKSUM_EN
                S_CKSUM: begin
                    if (take) begin
                        busy_q       <= 1'b0;
                        byte_ready_q <= 1'b0;
                        if (b == cks_q) begin
                            state_q    <= S_DONE;
                            done_q     <= 1'b1;
                            cpu_hold_q <= 1'b0;
                        end else begin
                            state_q <= S_ERR;
                            error_q <= 1'b1;
                        end
                    end
                end
`endif
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.byte_ready = byte_ready_q;
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = idx_q;
    assign bus.wr_data    = wr_data_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;
    assign cpu_hold       = cpu_hold_q;
endmodule
